maxpool_seq: RTL and testbench

Sequencer for the 2x2/stride-2 max-pool datapath. On a start command it streams one or more channel feature maps from the feature buffer into the pool unit in raster order, with no gaps. It also selects the pool geometry, collects the pooled outputs into the destination buffer at consecutive addresses, and reports completion. It sits between the layer controller, the feature/result buffers and the pool unit.

---
 rtl/maxpool_seq.sv | 132 +++++++++++++
 tb/tb_maxpool_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_seq.sv
// Max-pool sequencer: streams feature maps into the 2x2 pool unit
// and collects pooled outputs into the destination buffer.
`timescale 1ns/1ps
module maxpool_seq #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int CH_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              layer_sel,
    input  logic [CH_W-1:0]   num_ch,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pool_state,
    output logic              pool_ivalid,
    output logic [DATA_W-1:0] pool_din,
    input  logic              pool_ovalid,
    input  logic [DATA_W-1:0] pool_dout,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int CNT_W = CH_W + 10;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  tot_rd;
    logic [CNT_W-1:0]  tot_wr;
    logic [ADDR_W-1:0] dst_q;
    logic [TO_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]  px_per_ch;
    logic [CNT_W-1:0]  out_per_ch;
    logic [CNT_W-1:0]  wr_cnt_nx;

    assign px_per_ch  = layer_sel ? CNT_W'(64) : CNT_W'(576);
    assign out_per_ch = layer_sel ? CNT_W'(16) : CNT_W'(144);

    assign pool_din  = rd_data;
    assign wr_en     = pool_ovalid && (state == RUN || state == DRAIN);
    assign wr_data   = pool_dout;
    assign wr_addr   = dst_q + ADDR_W'(wr_cnt);
    assign wr_cnt_nx = wr_cnt + CNT_W'(wr_en);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            pool_state  <= 1'b0;
            pool_ivalid <= 1'b0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            tot_rd      <= '0;
            tot_wr      <= '0;
            dst_q       <= '0;
            idle_cnt    <= '0;
        end else begin
            pool_ivalid <= rd_en;
            wr_cnt      <= wr_cnt_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err_timeout <= 1'b0;
                        pool_state  <= layer_sel;
                        dst_q       <= dst_base;
                        tot_rd      <= CNT_W'(num_ch) * px_per_ch;
                        tot_wr      <= CNT_W'(num_ch) * out_per_ch;
                        rd_cnt      <= '0;
                        wr_cnt      <= '0;
                        idle_cnt    <= '0;
                        rd_addr     <= src_base;
                        if (num_ch != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            rd_en <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == tot_rd - 1'b1) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    idle_cnt <= pool_ovalid ? '0 : idle_cnt + 1'b1;
                    if (wr_cnt_nx >= tot_wr) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (!pool_ovalid &&
                                 idle_cnt == TO_W'(TIMEOUT - 1)) begin
                        // outputs went missing: give up rather than hang
                        err_timeout <= 1'b1;
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_seq.sv
// Bench for maxpool_seq: feature-buffer model, 2x2 pool model and
// a write scoreboard driven from one linear directed sequence.
`timescale 1ns/1ps
module tb_maxpool_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        layer_sel = 1'b0;
    logic [7:0]  num_ch = '0;
    logic [15:0] src_base = '0;
    logic [15:0] dst_base = '0;
    logic        busy, done, err_timeout, rd_en;
    logic [15:0] rd_addr;
    logic [31:0] rd_data = '0;
    logic        pool_state, pool_ivalid;
    logic [31:0] pool_din;
    logic        pool_ovalid = 1'b0;
    logic [31:0] pool_dout = '0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;

    always #5 clk = ~clk;

    maxpool_seq dut (
        .clk(clk), .rstn(rstn), .start(start), .layer_sel(layer_sel),
        .num_ch(num_ch), .src_base(src_base), .dst_base(dst_base),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pool_state(pool_state), .pool_ivalid(pool_ivalid),
        .pool_din(pool_din), .pool_ovalid(pool_ovalid),
        .pool_dout(pool_dout), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    function automatic logic signed [31:0] pix(input logic [15:0] a);
        logic [31:0] t;
        if (a >= 16'h100 && a < 16'h140)
            return 32'(a - 16'h100);
        t = {16'h0, a} * 32'd40503;
        t = t ^ (t >> 11) ^ (t << 17);
        return $signed(t);
    endfunction

    function automatic logic signed [31:0] smax(
        input logic signed [31:0] a, input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk)
        rd_data <= rd_en ? pix(rd_addr) : 32'h0;

    // pool model: pairs within a row, then max against the stored even row
    int emit_cnt;
    int emit_limit = 0;
    int col;
    int row;
    logic signed [31:0] prev_px;
    logic signed [31:0] rowbuf [0:11];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col <= 0;
            row <= 0;
            emit_cnt <= 0;
            pool_ovalid <= 1'b0;
            pool_dout <= '0;
        end else begin
            pool_ovalid <= 1'b0;
            if (!busy) emit_cnt <= 0;
            if (pool_ivalid) begin
                if (col[0] == 1'b0) begin
                    prev_px <= pool_din;
                end else if (row[0] == 1'b0) begin
                    rowbuf[col/2] <= smax(prev_px, pool_din);
                end else begin
                    if (emit_cnt < emit_limit) begin
                        pool_ovalid <= 1'b1;
                        pool_dout <= smax(rowbuf[col/2],
                                          smax(prev_px, pool_din));
                    end
                    emit_cnt <= emit_cnt + 1;
                end
                if (col == (pool_state ? 7 : 23)) begin
                    col <= 0;
                    row <= (row == (pool_state ? 7 : 23)) ? 0 : row + 1;
                end else begin
                    col <= col + 1;
                end
            end
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wexp_t;

    wexp_t       exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc_n = 0;
    int          rd_n, wr_n, done_n, rd_first, rd_last;
    logic [15:0] rd_base;
    logic        prev_rd = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic cyc();
        wexp_t e;
        @(negedge clk);
        cyc_n++;
        check("ivalid_pipe", 64'(pool_ivalid), 64'(prev_rd));
        prev_rd = rd_en;
        if (rd_en) begin
            check("rd_addr", 64'(rd_addr), 64'(rd_base) + 64'(rd_n));
            check("busy_rd", 64'(busy), 64'd1);
            if (rd_n == 0) rd_first = cyc_n;
            rd_last = cyc_n;
            rd_n++;
        end
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
            end
            wr_n++;
        end
        if (done) done_n++;
    endtask

    task automatic prep(input logic ls, input int nch,
                        input logic [15:0] src, input logic [15:0] dst,
                        input int sup);
        int w, p, q, idx;
        logic [15:0] a0;
        logic signed [31:0] v;
        w = ls ? 8 : 24;
        p = w * w;
        q = (w / 2) * (w / 2);
        exp_q.delete();
        for (int ch = 0; ch < nch; ch++)
            for (int r = 0; r < w / 2; r++)
                for (int k = 0; k < w / 2; k++) begin
                    a0 = 16'(int'(src) + ch * p + 2 * r * w + 2 * k);
                    v = smax(smax(pix(a0), pix(a0 + 16'd1)),
                             smax(pix(a0 + 16'(w)), pix(a0 + 16'(w + 1))));
                    idx = ch * q + r * (w / 2) + k;
                    if (idx < nch * q - sup)
                        exp_q.push_back('{16'(int'(dst) + idx), v});
                end
        emit_limit = nch * q - sup;
        rd_base = src;
        rd_n = 0;
        wr_n = 0;
        done_n = 0;
        layer_sel = ls;
        num_ch = 8'(nch);
        src_base = src;
        dst_base = dst;
    endtask

    task automatic run(input logic ls, input int nch,
                       input logic [15:0] src, input logic [15:0] dst,
                       input int sup, input bit poke, input bit exp_err);
        int p, q, lat;
        bit seen;
        p = ls ? 64 : 576;
        q = ls ? 16 : 144;
        prep(ls, nch, src, dst, sup);
        start = 1'b1;
        cyc();
        start = 1'b0;
        lat = 1;
        check("err_clear", 64'(err_timeout), 64'd0);
        seen = done;
        for (int i = 0; i < nch * p + 200 && !seen; i++) begin
            if (poke && i == 10) begin
                start = 1'b1;
                layer_sel = ~ls;
            end else if (poke && i == 11) begin
                start = 1'b0;
                layer_sel = ls;
            end
            cyc();
            lat++;
            seen = done;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        if (nch == 0) check("zero_done_lat", 64'(lat <= 2), 64'd1);
        for (int i = 0; i < 4; i++) cyc();
        check("done_once", 64'(done_n), 64'd1);
        check("rd_count", 64'(rd_n), 64'(nch * p));
        check("wr_count", 64'(wr_n), 64'(nch * q - sup));
        check("q_empty", 64'(exp_q.size()), 64'd0);
        if (rd_n > 0)
            check("rd_no_gap", 64'(rd_last - rd_first + 1), 64'(rd_n));
        check("pool_state", 64'(pool_state), 64'(ls));
        check("err_timeout", 64'(err_timeout), 64'(exp_err));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cyc();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_pool_state", 64'(pool_state), 64'd0);
        rstn = 1'b1;
        cyc();

        run(1'b1, 1, 16'h0100, 16'h0200, 0, 1'b0, 1'b0);
        run(1'b0, 2, 16'h1000, 16'h3000, 0, 1'b0, 1'b0);
        run(1'b0, 0, 16'h0500, 16'h0600, 0, 1'b0, 1'b0);
        run(1'b1, 1, 16'h0100, 16'h0200, 0, 1'b1, 1'b0);

        prep(1'b1, 1, 16'h0100, 16'h0200, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 100 && rd_n < 30; i++) cyc();
        check("pre_reset_reads", 64'(rd_n), 64'd30);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_rd_en", 64'(rd_en), 64'd0);
        check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
        check("mid_rst_ivalid", 64'(pool_ivalid), 64'd0);
        check("mid_rst_pool_state", 64'(pool_state), 64'd0);
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        exp_q.delete();
        prev_rd = 1'b0;
        cyc();
        rstn = 1'b1;
        cyc();
        run(1'b1, 1, 16'h0100, 16'h0200, 0, 1'b0, 1'b0);

        run(1'b1, 1, 16'h0100, 16'h0200, 2, 1'b0, 1'b1);
        run(1'b1, 1, 16'h0180, 16'h0280, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
